// File: rtl/vegeta_array_ctrl.sv
// Sequencer for the VEGETA systolic array: double-buffered weight loads, skewed per-row
// activation injection, per-column output valids and job completion.
module vegeta_array_ctrl #(
  parameter int unsigned X_SCALED = 4,
  parameter int unsigned Y_SCALED = 4,
  parameter int unsigned TREE_LAT = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          cfg_num_tiles,
  input  logic [CNT_W-1:0]    cfg_rows,
  input  logic [1:0]          cfg_mode,
  input  logic [1:0]          cfg_gemm_mode,
  input  logic                w_avail,
  input  logic                act_avail,
  output logic                busy,
  output logic                done,
  output logic [1:0]          mode,
  output logic [1:0]          gemm_mode,
  output logic                weight_transferring_in,
  output logic                w_rd_en,
  output logic                i_wb,
  output logic [X_SCALED-1:0] act_rd_en,
  output logic [Y_SCALED-1:0] out_valid
);

  // One delay tap per cycle of skew up to the last column's output valid.
  localparam int unsigned Dly = X_SCALED + TREE_LAT + Y_SCALED - 1;
  localparam int unsigned Lcw = (X_SCALED > 1) ? $clog2(X_SCALED) : 1;

  typedef enum logic [1:0] {StIdle, StLoad0, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [7:0]       tiles_q, tile_q;
  logic [CNT_W-1:0] rows_q, inj_cnt_q;
  logic [Lcw-1:0]   load_cnt_q;
  logic             load_q, next_loaded_q, i_wb_q, zdone_q;
  logic [1:0]       mode_q, gemm_q;
  logic [Dly:1]     sr_q;

  logic zero_cfg, last_tile, load_start, w_en, load_last, inj, drain_exit, accept;

  always_comb begin
    zero_cfg   = (cfg_num_tiles == 8'd0) || (cfg_rows == '0);
    accept     = (state_q == StIdle) && start && !zero_cfg;
    last_tile  = (tile_q == tiles_q - 8'd1);
    // The next tile loads into the idle buffer while the current tile runs or drains.
    load_start = !load_q && w_avail &&
                 ((state_q == StLoad0) ||
                  (((state_q == StRun) || (state_q == StDrain)) && !last_tile && !next_loaded_q));
    w_en       = load_q || load_start;
    load_last  = w_en && (load_cnt_q == Lcw'(X_SCALED - 1));
    inj        = (state_q == StRun) && act_avail && (inj_cnt_q < rows_q);
    drain_exit = (state_q == StDrain) && (sr_q == '0) && !load_q &&
                 (last_tile || next_loaded_q);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StLoad0;
      StLoad0: if (load_last) state_d = StRun;
      StRun:   if (inj && (inj_cnt_q == rows_q - CNT_W'(1))) state_d = StDrain;
      StDrain: if (drain_exit) state_d = last_tile ? StIdle : StRun;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      tiles_q       <= '0;
      tile_q        <= '0;
      rows_q        <= '0;
      inj_cnt_q     <= '0;
      load_cnt_q    <= '0;
      load_q        <= 1'b0;
      next_loaded_q <= 1'b0;
      i_wb_q        <= 1'b0;
      zdone_q       <= 1'b0;
      mode_q        <= '0;
      gemm_q        <= '0;
      sr_q          <= '0;
    end else begin
      state_q <= state_d;
      zdone_q <= (state_q == StIdle) && start && zero_cfg;

      if (accept) begin
        tiles_q       <= cfg_num_tiles;
        rows_q        <= cfg_rows;
        mode_q        <= cfg_mode;
        gemm_q        <= cfg_gemm_mode;
        tile_q        <= '0;
        inj_cnt_q     <= '0;
        next_loaded_q <= 1'b0;
      end

      if (w_en) begin
        if (load_last) begin
          load_q     <= 1'b0;
          load_cnt_q <= '0;
          i_wb_q     <= ~i_wb_q;
        end else begin
          load_q     <= 1'b1;
          load_cnt_q <= load_cnt_q + Lcw'(1);
        end
      end

      if (load_start && (state_q != StLoad0)) next_loaded_q <= 1'b1;
      if (inj) inj_cnt_q <= inj_cnt_q + CNT_W'(1);

      if (drain_exit && !last_tile) begin
        tile_q        <= tile_q + 8'd1;
        inj_cnt_q     <= '0;
        next_loaded_q <= 1'b0;
      end

      sr_q[1] <= inj;
      for (int k = 2; k <= int'(Dly); k++) sr_q[k] <= sr_q[k-1];
    end
  end

  always_comb begin
    busy                   = (state_q != StIdle);
    done                   = zdone_q || (drain_exit && last_tile);
    mode                   = mode_q;
    gemm_mode              = gemm_q;
    weight_transferring_in = w_en;
    w_rd_en                = w_en;
    i_wb                   = i_wb_q;
    act_rd_en              = '0;
    act_rd_en[0]           = inj;
    for (int i = 1; i < int'(X_SCALED); i++) act_rd_en[i] = sr_q[i];
    out_valid = '0;
    for (int j = 0; j < int'(Y_SCALED); j++) out_valid[j] = sr_q[X_SCALED + TREE_LAT + j];
  end

endmodule

// File: tb/tb_vegeta_array_ctrl.sv
// Directed bench for vegeta_array_ctrl: per-cycle expected output vectors are queued when a
// job's stimulus is set up and popped/compared each cycle as the DUT runs.
module tb_vegeta_array_ctrl;
  localparam int X = 4, Y = 4, TL = 2, CW = 16, LAT = X + TL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    cfg_num_tiles = '0;
  logic [CW-1:0] cfg_rows = '0;
  logic [1:0]    cfg_mode = '0, cfg_gemm_mode = '0;
  logic          w_avail = 1'b0, act_avail = 1'b0;
  logic          busy, done, weight_transferring_in, w_rd_en, i_wb;
  logic [1:0]    mode, gemm_mode;
  logic [X-1:0]  act_rd_en;
  logic [Y-1:0]  out_valid;

  vegeta_array_ctrl #(.X_SCALED(X), .Y_SCALED(Y), .TREE_LAT(TL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_tiles(cfg_num_tiles), .cfg_rows(cfg_rows),
    .cfg_mode(cfg_mode), .cfg_gemm_mode(cfg_gemm_mode), .w_avail(w_avail),
    .act_avail(act_avail), .busy(busy), .done(done), .mode(mode), .gemm_mode(gemm_mode),
    .weight_transferring_in(weight_transferring_in), .w_rd_en(w_rd_en), .i_wb(i_wb),
    .act_rd_en(act_rd_en), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef logic [16:0] vec_t;  // {busy,done,wti,w_rd_en,i_wb,act[3:0],ov[3:0],mode,gemm}
  vec_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  logic e_w[64], e_inj[64], e_done[64], e_busy[64], e_iwb[64];
  logic st[64], wav[64], aav[64];

  function automatic vec_t obs_vec();
    return {busy, done, weight_transferring_in, w_rd_en, i_wb, act_rd_en, out_valid,
            mode, gemm_mode};
  endfunction

  task automatic chk(input string tag, input int c, input vec_t obs, input vec_t expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, obs, expv);
    end
  endtask

  task automatic clr();
    for (int c = 0; c < 64; c++) begin
      e_w[c] = 0; e_inj[c] = 0; e_done[c] = 0; e_busy[c] = 0; e_iwb[c] = 0;
      st[c] = 0; wav[c] = 1; aav[c] = 1;
    end
    st[0] = 1;
    exp_q.delete();
  endtask

  // kind: 0 weight load, 1 injection (act_rd_en[0]), 2 done, 3 busy, 4 i_wb
  task automatic set(input int kind, input int lo, input int hi);
    for (int c = lo; c <= hi; c++)
      case (kind)
        0: e_w[c] = 1;
        1: e_inj[c] = 1;
        2: e_done[c] = 1;
        3: e_busy[c] = 1;
        default: e_iwb[c] = 1;
      endcase
  endtask

  // Row i sees the injection pattern delayed by i; column j by LAT+j.
  task automatic build(input int len, input bit lat);
    logic [3:0] a, o;
    logic [1:0] m, g;
    for (int c = 0; c < len; c++) begin
      for (int i = 0; i < 4; i++) begin
        a[i] = (c >= i) ? e_inj[c-i] : 1'b0;
        o[i] = (c >= LAT + i) ? e_inj[c-LAT-i] : 1'b0;
      end
      m = (lat && c >= 1) ? 2'b10 : 2'b00;
      g = (lat && c >= 1) ? 2'b01 : 2'b00;
      exp_q.push_back({e_busy[c], e_done[c], e_w[c], e_w[c], e_iwb[c], a, o, m, g});
    end
  endtask

  task automatic run(input string tag, input int len);
    for (int c = 0; c < len; c++) begin
      start         = st[c];
      w_avail       = wav[c];
      act_avail     = aav[c];
      cfg_mode      = (c == 0) ? 2'b10 : 2'b11;
      cfg_gemm_mode = (c == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      chk(tag, c, obs_vec(), exp_q.pop_front());
      @(posedge clk);
      #1;
    end
    start = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    chk("reset_async", 0, obs_vec(), '0);
    @(negedge clk);
    chk("reset_hold", 0, obs_vec(), '0);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic job_basic();
    clr();
    set(0, 1, 4); set(1, 5, 7); set(2, 17, 17); set(3, 1, 17); set(4, 5, 63);
    cfg_num_tiles = 1; cfg_rows = 3;
  endtask

  initial begin
    // Single tile, 3 rows.
    job_basic(); build(20, 1); do_reset(); run("basic", 20);

    // Two tiles of 8 rows: second load overlaps RUN into buffer 1.
    clr();
    set(0, 1, 8); set(1, 5, 12); set(1, 23, 30); set(2, 40, 40); set(3, 1, 40); set(4, 5, 8);
    cfg_num_tiles = 2; cfg_rows = 8;
    build(44, 1); do_reset(); run("two_tiles", 44);

    // Activation bubble of two cycles mid-tile.
    clr();
    aav[7] = 0; aav[8] = 0;
    set(0, 1, 4); set(1, 5, 6); set(1, 9, 12); set(2, 22, 22); set(3, 1, 22); set(4, 5, 63);
    cfg_num_tiles = 1; cfg_rows = 6;
    build(25, 1); do_reset(); run("act_bubble", 25);

    // Weights unavailable for five cycles after start.
    clr();
    for (int c = 0; c <= 5; c++) wav[c] = 0;
    set(0, 6, 9); set(1, 10, 11); set(2, 21, 21); set(3, 1, 21); set(4, 10, 63);
    cfg_num_tiles = 1; cfg_rows = 2;
    build(24, 1); do_reset(); run("w_late", 24);

    // Empty jobs complete immediately without leaving IDLE.
    clr(); set(2, 1, 1); cfg_num_tiles = 0; cfg_rows = 5;
    build(4, 0); do_reset(); run("zero_tiles", 4);
    clr(); set(2, 1, 1); cfg_num_tiles = 2; cfg_rows = 0;
    build(4, 0); run("zero_rows", 4);

    // Starts while busy (including the done cycle) are ignored.
    job_basic();
    st[3] = 1; st[10] = 1; st[17] = 1;
    build(22, 1); do_reset(); run("start_busy", 22);

    // Reset during RUN aborts at once; a fresh job then runs normally.
    job_basic(); build(20, 1); do_reset(); run("pre_abort", 7);
    exp_q.delete();
    act_avail = 1; w_avail = 1;
    #1 rst = 1;
    #1 chk("abort_now", 7, obs_vec(), '0);
    @(negedge clk);
    chk("abort_hold", 7, obs_vec(), '0);
    @(posedge clk);
    #1 rst = 0;
    job_basic(); build(20, 1); run("after_abort", 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
